// File: rtl/axi_packet_gate_ext.sv
// Store-and-forward AXI-Stream gate: a packet is released only once its
// tlast is accepted without terror; errored or oversized packets are rewound.
module axi_packet_gate_ext #(
   parameter int WIDTH         = 32,
   parameter int USER_WIDTH    = 1,
   parameter int SIZE          = 10,
   parameter int DROP_OVERSIZE = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [WIDTH-1:0]      i_tdata,
   input  logic [USER_WIDTH-1:0] i_tuser,
   input  logic                  i_tlast,
   input  logic                  i_terror,
   input  logic                  i_tvalid,
   output logic                  i_tready,
   output logic [WIDTH-1:0]      o_tdata,
   output logic [USER_WIDTH-1:0] o_tuser,
   output logic                  o_tlast,
   output logic                  o_tvalid,
   input  logic                  o_tready,
   output logic [SIZE:0]         occupied,
   output logic [SIZE:0]         pkt_count,
   output logic [15:0]           drop_count,
   output logic                  drop_pulse
);

   localparam int DEPTH = 2 ** SIZE;
   localparam int RW    = USER_WIDTH + 1 + WIDTH;

   typedef enum logic {
      ACCEPT,
      DISCARD
   } wstate_t;

   logic [RW-1:0]   mem [DEPTH];
   logic [RW-1:0]   pf_q;
   logic [RW-1:0]   out_q;
   logic            pf_valid;
   logic [SIZE:0]   wr_ptr;
   logic [SIZE:0]   commit_ptr;
   logic [SIZE:0]   rd_ptr;
   logic [SIZE-1:0] len;
   logic            run;
   wstate_t         state;

   logic full, in_hs, acc, oversize;
   logic drop_err, drop_ovr, drop;
   logic wr_en, commit;
   logic out_hs, out_adv, fetch, rd_last;

   assign full     = (wr_ptr - rd_ptr) == (SIZE + 1)'(DEPTH);
   assign i_tready = run & ~clear & ((state == DISCARD) | ~full);
   assign in_hs    = i_tvalid & i_tready;
   assign acc      = in_hs & (state == ACCEPT);
   assign oversize = (DROP_OVERSIZE != 0) & ~i_tlast & (len == '1);
   assign drop_err = acc & i_tlast & i_terror;
   assign drop_ovr = acc & oversize;
   assign drop     = drop_err | drop_ovr;
   assign wr_en    = acc & ~drop;
   assign commit   = wr_en & i_tlast;

   // Two-stage read: RAM prefetch register, then the FWFT output register
   assign out_hs   = o_tvalid & o_tready;
   assign out_adv  = ~o_tvalid | o_tready;
   assign fetch    = (rd_ptr != commit_ptr) & (~pf_valid | out_adv);
   assign rd_last  = out_hs & o_tlast;

   assign o_tuser  = out_q[RW-1 -: USER_WIDTH];
   assign o_tlast  = out_q[WIDTH];
   assign o_tdata  = out_q[WIDTH-1:0];
   assign occupied = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[SIZE-1:0]] <= {i_tuser, i_tlast, i_tdata};
      if (fetch)
         pf_q <= mem[rd_ptr[SIZE-1:0]];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run        <= 1'b0;
         state      <= ACCEPT;
         len        <= '0;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         pf_valid   <= 1'b0;
         o_tvalid   <= 1'b0;
         out_q      <= '0;
         pkt_count  <= '0;
         drop_count <= '0;
         drop_pulse <= 1'b0;
      end else begin
         run        <= 1'b1;
         drop_pulse <= 1'b0;
         if (clear) begin
            state      <= ACCEPT;
            len        <= '0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pf_valid   <= 1'b0;
            o_tvalid   <= 1'b0;
            out_q      <= '0;
            pkt_count  <= '0;
         end else begin
            if (drop)
               wr_ptr <= commit_ptr;
            else if (wr_en)
               wr_ptr <= wr_ptr + 1'b1;
            if (commit)
               commit_ptr <= wr_ptr + 1'b1;

            if (drop_ovr) begin
               state <= DISCARD;
               len   <= '0;
            end else if (acc) begin
               len <= i_tlast ? '0 : len + 1'b1;
            end else if (in_hs && i_tlast) begin
               state <= ACCEPT;
            end

            if (fetch)
               rd_ptr <= rd_ptr + 1'b1;
            pf_valid <= fetch | (pf_valid & ~out_adv);
            if (out_adv) begin
               o_tvalid <= pf_valid;
               if (pf_valid)
                  out_q <= pf_q;
            end

            unique case ({commit, rd_last})
               2'b10:   pkt_count <= pkt_count + 1'b1;
               2'b01:   pkt_count <= pkt_count - 1'b1;
               default: pkt_count <= pkt_count;
            endcase

            if (drop) begin
               drop_pulse <= 1'b1;
               if (drop_count != 16'hFFFF)
                  drop_count <= drop_count + 1'b1;
            end
         end
      end
   end

endmodule
